// File: rtl/lsu_pkg.sv
// Shared types for the LSU bus port: size codes, FSM states and the per-beat descriptor.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'd0,
        SZ_HALF     = 2'd1,
        SZ_WORD     = 2'd2,
        SZ_WORD_ALT = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // addr_off: byte offset added to the request address; res_off: result byte fed by the lowest enabled lane
    typedef struct packed {
        logic [1:0] addr_off;
        logic [1:0] be;
        logic [1:0] res_off;
    } beat_t;

    localparam int MAX_BEATS  = 3;
    localparam int BEAT_IDX_W = $clog2(MAX_BEATS);

endpackage

// File: rtl/lsu_beat_planner.sv
// Combinational beat planner: maps (address LSB, size, beat index) to a bus beat descriptor.
// Misaligned half/word splitting is enabled by defining LSU_MISALIGNED_EN.
module lsu_beat_planner
    import lsu_pkg::*;
(
    input  logic                  addr_lsb_i,
    input  logic [1:0]            size_i,
    input  logic [BEAT_IDX_W-1:0] beat_idx_i,
    output beat_t                 beat_o,
    output logic                  last_o,
    output logic                  unsupported_o
);

    always_comb begin
        beat_o        = '0;
        last_o        = 1'b1;
        unsupported_o = 1'b0;
        unique case (size_e'(size_i))
            SZ_BYTE: begin
                beat_o.be = addr_lsb_i ? 2'b10 : 2'b01;
            end
            SZ_HALF: begin
                if (!addr_lsb_i) begin
                    beat_o.be = 2'b11;
                end else begin
`ifdef LSU_MISALIGNED_EN
                    if (beat_idx_i == 2'd0) begin
                        beat_o = '{addr_off: 2'd0, be: 2'b10, res_off: 2'd0};
                        last_o = 1'b0;
                    end else begin
                        beat_o = '{addr_off: 2'd1, be: 2'b01, res_off: 2'd1};
                    end
`else
                    unsupported_o = 1'b1;
`endif
                end
            end
            default: begin
                if (!addr_lsb_i) begin
                    if (beat_idx_i == 2'd0) begin
                        beat_o = '{addr_off: 2'd0, be: 2'b11, res_off: 2'd0};
                        last_o = 1'b0;
                    end else begin
                        beat_o = '{addr_off: 2'd2, be: 2'b11, res_off: 2'd2};
                    end
                end else begin
`ifdef LSU_MISALIGNED_EN
                    if (beat_idx_i == 2'd0) begin
                        beat_o = '{addr_off: 2'd0, be: 2'b10, res_off: 2'd0};
                        last_o = 1'b0;
                    end else if (beat_idx_i == 2'd1) begin
                        beat_o = '{addr_off: 2'd1, be: 2'b11, res_off: 2'd1};
                        last_o = 1'b0;
                    end else begin
                        beat_o = '{addr_off: 2'd3, be: 2'b01, res_off: 2'd3};
                    end
`else
                    unsupported_o = 1'b1;
`endif
                end
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_port.sv
// Load/store responder: splits one request into 16-bit little-endian bus beats and writes back loads.
// Optional feature macro: LSU_MISALIGNED_EN (misaligned half/word split into byte-lane beats).
module lsu_bus_port
    import lsu_pkg::*;
#(
    parameter int NUM_REGS = 64,
    parameter int ADDR_W   = 28,
    parameter int REG_IDX  = $clog2(NUM_REGS) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [31:0]       loadstore_address,
    input  logic [1:0]        loadstore_size,
    input  logic              sign_extend,
    input  logic [31:0]       store_val,
    input  logic [REG_IDX:0]  dest_idx,
    output logic              busy,
    output logic              wb_valid,
    output logic [REG_IDX:0]  wb_idx,
    output logic [31:0]       wb_val,
    output logic              misaligned,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [1:0]        bus_be,
    output logic [15:0]       bus_wdata,
    input  logic [15:0]       bus_rdata,
    input  logic              bus_ack
);

    state_e                state_q;
    logic                  ld_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [1:0]            size_q;
    logic                  sext_q;
    logic [31:0]           sdata_q;
    logic [REG_IDX:0]      dest_q;
    logic [BEAT_IDX_W-1:0] beat_q;
    logic [31:0]           acc_q;
    logic [31:0]           acc_d;
    logic                  wb_valid_q;
    logic                  mis_q;

    logic                  req;
    logic                  in_beat;
    beat_t                 beat;
    logic                  last;
    logic                  unsupported;
    logic [1:0]            lane0_idx;
    logic [1:0]            lane1_idx;
    logic [ADDR_W-1:0]     beat_addr;
    logic [15:0]           wdata_d;

    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^loadstore_address[31:ADDR_W];
        end
    endgenerate

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz, input logic sx);
        case (size_e'(sz))
            SZ_BYTE: return sx ? {{24{v[7]}}, v[7:0]}   : {24'h0, v[7:0]};
            SZ_HALF: return sx ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign req     = is_load | is_store;
    assign in_beat = (state_q == ST_BEAT);

    // In IDLE the planner looks at the incoming request so a misaligned one can skip straight to DONE
    lsu_beat_planner u_planner (
        .addr_lsb_i    (in_beat ? addr_q[0] : loadstore_address[0]),
        .size_i        (in_beat ? size_q : loadstore_size),
        .beat_idx_i    (in_beat ? beat_q : '0),
        .beat_o        (beat),
        .last_o        (last),
        .unsupported_o (unsupported)
    );

    assign lane0_idx = beat.res_off;
    assign lane1_idx = beat.be[0] ? beat.res_off + 2'd1 : beat.res_off;
    assign beat_addr = addr_q + ADDR_W'(beat.addr_off);

    always_comb begin
        wdata_d = '0;
        acc_d   = acc_q;
        if (beat.be[0]) begin
            wdata_d[7:0]                  = sdata_q[{lane0_idx, 3'b000} +: 8];
            acc_d[{lane0_idx, 3'b000} +: 8] = bus_rdata[7:0];
        end
        if (beat.be[1]) begin
            wdata_d[15:8]                 = sdata_q[{lane1_idx, 3'b000} +: 8];
            acc_d[{lane1_idx, 3'b000} +: 8] = bus_rdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ld_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            sext_q     <= 1'b0;
            sdata_q    <= '0;
            dest_q     <= '0;
            beat_q     <= '0;
            acc_q      <= '0;
            wb_valid_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        ld_q    <= is_load;
                        addr_q  <= loadstore_address[ADDR_W-1:0];
                        size_q  <= loadstore_size;
                        sext_q  <= sign_extend;
                        sdata_q <= store_val;
                        dest_q  <= dest_idx;
                        beat_q  <= '0;
                        acc_q   <= '0;
                        if (unsupported) begin
                            state_q <= ST_DONE;
                            mis_q   <= 1'b1;
                        end else begin
                            state_q <= ST_BEAT;
                        end
                    end
                end
                ST_BEAT: begin
                    if (bus_ack) begin
                        if (ld_q) begin
                            acc_q <= acc_d;
                        end
                        beat_q <= beat_q + 1'b1;
                        if (last) begin
                            state_q    <= ST_DONE;
                            wb_valid_q <= ld_q;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = ((state_q == ST_IDLE) & req) | in_beat;
    assign wb_valid   = wb_valid_q;
    assign wb_idx     = dest_q;
    assign wb_val     = extend(acc_q, size_q, sext_q);
    assign misaligned = mis_q;
    assign bus_req    = in_beat;
    assign bus_we     = in_beat & ~ld_q;
    assign bus_addr   = in_beat ? {beat_addr[ADDR_W-1:1], 1'b0} : '0;
    assign bus_be     = in_beat ? beat.be : 2'b00;
    assign bus_wdata  = (in_beat & ~ld_q) ? wdata_d : 16'h0;

endmodule

// File: tb/tb_lsu_bus_port.sv
// Scoreboard bench for lsu_bus_port: stimulus queues expected beats/write-backs, monitors pop and compare.
module tb_lsu_bus_port;

    typedef struct {
        logic [27:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          waits;
    } exp_beat_t;

    typedef struct {
        logic        mis;
        logic [5:0]  idx;
        logic [31:0] val;
        int          cyc;
    } exp_wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [31:0] loadstore_address = '0;
    logic [1:0]  loadstore_size = '0;
    logic        sign_extend = 1'b0;
    logic [31:0] store_val = '0;
    logic [5:0]  dest_idx = '0;
    logic        busy;
    logic        wb_valid;
    logic [5:0]  wb_idx;
    logic [31:0] wb_val;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [27:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    exp_beat_t beat_q[$];
    exp_wb_t   wb_q[$];
    int        n_cmp = 0;
    int        n_bad = 0;
    int        cyc = 0;

    lsu_bus_port dut (
        .clk               (clk),
        .rst               (rst),
        .is_load           (is_load),
        .is_store          (is_store),
        .loadstore_address (loadstore_address),
        .loadstore_size    (loadstore_size),
        .sign_extend       (sign_extend),
        .store_val         (store_val),
        .dest_idx          (dest_idx),
        .busy              (busy),
        .wb_valid          (wb_valid),
        .wb_idx            (wb_idx),
        .wb_val            (wb_val),
        .misaligned        (misaligned),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_be            (bus_be),
        .bus_wdata         (bus_wdata),
        .bus_rdata         (bus_rdata),
        .bus_ack           (bus_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bus responder and beat checker
    exp_beat_t cur;
    logic      active = 1'b0;
    int        wcnt = 0;
    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (rst) begin
            active = 1'b0;
        end else if (bus_req) begin
            if (!active) begin
                if (beat_q.size() == 0) begin
                    n_cmp = n_cmp + 1;
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_beat: got addr %h be %b, expected none", bus_addr, bus_be);
                    cur = '{addr: bus_addr, be: bus_be, we: bus_we, wdata: bus_wdata, rdata: 16'h0, waits: 0};
                end else begin
                    cur = beat_q.pop_front();
                end
                active = 1'b1;
                wcnt   = cur.waits;
            end
            if (wcnt == 0) begin
                chk("bus_addr", 32'(bus_addr), 32'(cur.addr));
                chk("bus_be", 32'(bus_be), 32'(cur.be));
                chk("bus_we", 32'(bus_we), 32'(cur.we));
                chk("bus_wdata", 32'(bus_wdata), 32'(cur.wdata));
                bus_rdata = cur.rdata;
                bus_ack   = 1'b1;
                active    = 1'b0;
            end else begin
                wcnt = wcnt - 1;
            end
        end
    end

    // Write-back / fault monitor
    always @(negedge clk) begin
        exp_wb_t w;
        if (!rst && (wb_valid || misaligned)) begin
            if (wb_q.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_bad = n_bad + 1;
                $display("FAIL unexpected_wb: got wb_valid %b misaligned %b, expected neither", wb_valid, misaligned);
            end else begin
                w = wb_q.pop_front();
                chk("wb_valid", 32'(wb_valid), 32'(!w.mis));
                chk("misaligned", 32'(misaligned), 32'(w.mis));
                if (!w.mis) begin
                    chk("wb_idx", 32'(wb_idx), 32'(w.idx));
                    chk("wb_val", wb_val, w.val);
                end
                if (w.cyc >= 0) chk("wb_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
    end

    task automatic push_beat(input logic [27:0] a, input logic [1:0] be, input logic we,
                             input logic [15:0] wd, input logic [15:0] rd, input int waits);
        beat_q.push_back('{addr: a, be: be, we: we, wdata: wd, rdata: rd, waits: waits});
    endtask

    // Called just after a rising edge; holds the request until busy drops (DONE cycle).
    task automatic issue(input logic ld, input logic [31:0] a, input logic [1:0] sz, input logic sx,
                         input logic [31:0] sv, input logic [5:0] di, input int busy_exp,
                         input logic exp_wb, input logic exp_mis, input logic [31:0] exp_val,
                         input int lat);
        int   n;
        logic b;
        is_load           = ld;
        is_store          = !ld;
        loadstore_address = a;
        loadstore_size    = sz;
        sign_extend       = sx;
        store_val         = sv;
        dest_idx          = di;
        if (exp_wb || exp_mis)
            wb_q.push_back('{mis: exp_mis, idx: di, val: exp_val, cyc: (lat >= 0) ? cyc + lat : -1});
        n = 0;
        do begin
            @(negedge clk);
            b = busy;
            n = n + 1;
            @(posedge clk);
            #1;
        end while (b && n < 100);
        is_load  = 1'b0;
        is_store = 1'b0;
        chk("busy_cycles", 32'(n - 1), 32'(busy_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb", {wb_val[31:6], wb_val[5:0] | wb_idx}, 0);
        chk("rst_misaligned", 32'(misaligned), 0);
        chk("rst_bus", {bus_req, bus_we, bus_be, bus_addr}, 0);
        chk("rst_wdata", 32'(bus_wdata), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Byte load, odd address, sign-extended; write-back two cycles after accept
        push_beat(28'h100, 2'b10, 1'b0, 16'h0, 16'h80AA, 0);
        issue(1'b1, 32'h101, 2'd0, 1'b1, 32'h0, 6'd5, 2, 1'b1, 1'b0, 32'hFFFFFF80, 2);

        // Word load, two wait states on the second beat
        push_beat(28'h200, 2'b11, 1'b0, 16'h0, 16'h5678, 0);
        push_beat(28'h202, 2'b11, 1'b0, 16'h0, 16'h1234, 2);
        issue(1'b1, 32'h200, 2'd2, 1'b0, 32'h0, 6'd7, 5, 1'b1, 1'b0, 32'h12345678, -1);

        // Half store, back to back
        push_beat(28'h010, 2'b11, 1'b1, 16'hBEEF, 16'h0, 0);
        issue(1'b0, 32'h10, 2'd1, 1'b0, 32'hDEADBEEF, 6'd1, 2, 1'b0, 1'b0, 32'h0, -1);

        // Misaligned word load at 0x3
`ifdef LSU_MISALIGNED_EN
        push_beat(28'h002, 2'b10, 1'b0, 16'h0, 16'h11AA, 0);
        push_beat(28'h004, 2'b11, 1'b0, 16'h0, 16'h3322, 1);
        push_beat(28'h006, 2'b01, 1'b0, 16'h0, 16'hBB44, 0);
        issue(1'b1, 32'h3, 2'd2, 1'b0, 32'h0, 6'd9, 5, 1'b1, 1'b0, 32'h44332211, -1);
`else
        issue(1'b1, 32'h3, 2'd2, 1'b0, 32'h0, 6'd9, 1, 1'b0, 1'b1, 32'h0, 1);
`endif

        // Byte store to odd address: upper lane only
        push_beat(28'h032, 2'b10, 1'b1, 16'h9900, 16'h0, 1);
        issue(1'b0, 32'h33, 2'd0, 1'b0, 32'h12345699, 6'd2, 3, 1'b0, 1'b0, 32'h0, -1);

        // Half load, zero- then sign-extended
        push_beat(28'h040, 2'b11, 1'b0, 16'h0, 16'h8001, 0);
        issue(1'b1, 32'h40, 2'd1, 1'b0, 32'h0, 6'd10, 2, 1'b1, 1'b0, 32'h00008001, 2);
        push_beat(28'h040, 2'b11, 1'b0, 16'h0, 16'h8001, 0);
        issue(1'b1, 32'h40, 2'd1, 1'b1, 32'h0, 6'd11, 2, 1'b1, 1'b0, 32'hFFFF8001, 2);

        // Byte load, even address, zero-extended
        push_beat(28'h050, 2'b01, 1'b0, 16'h0, 16'h7F80, 0);
        issue(1'b1, 32'h50, 2'd0, 1'b0, 32'h0, 6'd12, 2, 1'b1, 1'b0, 32'h00000080, -1);

        // Size 3 as word; upper address bits ignored and second beat wraps to 0
        push_beat(28'hFFFFFFE, 2'b11, 1'b0, 16'h0, 16'hCDEF, 0);
        push_beat(28'h0000000, 2'b11, 1'b0, 16'h0, 16'h89AB, 0);
        issue(1'b1, 32'hAFFFFFFE, 2'd3, 1'b1, 32'h0, 6'd63, 3, 1'b1, 1'b0, 32'h89ABCDEF, 3);

        // Misaligned half store at 0x21
`ifdef LSU_MISALIGNED_EN
        push_beat(28'h020, 2'b10, 1'b1, 16'hB200, 16'h0, 0);
        push_beat(28'h022, 2'b01, 1'b1, 16'h00A1, 16'h0, 0);
        issue(1'b0, 32'h21, 2'd1, 1'b0, 32'h0000A1B2, 6'd0, 3, 1'b0, 1'b0, 32'h0, -1);
`else
        issue(1'b0, 32'h21, 2'd1, 1'b0, 32'h0000A1B2, 6'd0, 1, 1'b0, 1'b1, 32'h0, -1);
`endif

        // Aligned word store
        push_beat(28'h300, 2'b11, 1'b1, 16'hF00D, 16'h0, 0);
        push_beat(28'h302, 2'b11, 1'b1, 16'hCAFE, 16'h0, 0);
        issue(1'b0, 32'h300, 2'd2, 1'b0, 32'hCAFEF00D, 6'd0, 3, 1'b0, 1'b0, 32'h0, -1);

        // Reset during a wait state aborts the load
        push_beat(28'h400, 2'b11, 1'b0, 16'h0, 16'h1111, 20);
        is_load           = 1'b1;
        loadstore_address = 32'h400;
        loadstore_size    = 2'd2;
        dest_idx          = 6'd3;
        repeat (3) @(posedge clk);
        #1;
        is_load = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_bus_req", 32'(bus_req), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_wb_valid", 32'(wb_valid), 0);
        repeat (3) @(posedge clk);
        #1;

        // Recovery transaction after the abort
        push_beat(28'h100, 2'b10, 1'b0, 16'h0, 16'h80AA, 0);
        issue(1'b1, 32'h101, 2'd0, 1'b1, 32'h0, 6'd21, 2, 1'b1, 1'b0, 32'hFFFFFF80, 2);

        repeat (5) @(posedge clk);
        #1;
        chk("beat_queue_drained", 32'(beat_q.size()), 0);
        chk("wb_queue_drained", 32'(wb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
